// File: rtl/muldiv_seq_pkg.sv
// Shared opcodes and FSM state type for the iterative multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/writeback bundle between the EX stage (master) and the mul/div sequencer (slave).
interface muldiv_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              start_i;
  logic              op_i;
  logic [DATA_W-1:0] op1_i;
  logic [DATA_W-1:0] op2_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              flush_i;
  logic              busy_o;
  logic              hold_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_wen_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  busy_o, hold_o, rd_addr_o, rd_data_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    output busy_o, hold_o, rd_addr_o, rd_data_o, rd_wen_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider; one iteration per cycle,
// DATA_W iterations per operation, single-cycle writeback strobe on completion.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input logic        clk,
  input logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  md_state_e         state_q;
  logic              op_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [DATA_W:0]   acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_wen_q;
  logic              busy_q;

  logic [DATA_W:0]   acc_d;
  logic [DATA_W-1:0] op1_d, op2_d;
  logic [DATA_W+1:0] trial;
  logic              last_iter;

  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

  // MUL: op1 = shifting multiplicand, op2 = shifting multiplier, acc = partial product.
  // DIV: op1 shifts the dividend out MSB-first while quotient bits shift in at the LSB;
  //      acc holds the partial remainder, trial's top bit is the subtract borrow.
  always_comb begin
    acc_d = acc_q;
    op1_d = op1_q;
    op2_d = op2_q;
    trial = {acc_q, op1_q[DATA_W-1]} - {2'b00, op2_q};
    if (op_q == MD_OP_MUL) begin
      if (op2_q[0]) begin
        acc_d = {1'b0, acc_q[DATA_W-1:0] + op1_q};
      end
      op1_d = op1_q << 1;
      op2_d = op2_q >> 1;
    end else begin
      if (trial[DATA_W+1]) begin
        acc_d = {acc_q[DATA_W-1:0], op1_q[DATA_W-1]};
        op1_d = {op1_q[DATA_W-2:0], 1'b0};
      end else begin
        acc_d = trial[DATA_W:0];
        op1_d = {op1_q[DATA_W-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_OP_MUL;
      op1_q     <= '0;
      op2_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wen_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rd_wen_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            op_q    <= bus.op_i;
            op1_q   <= bus.op1_i;
            op2_q   <= bus.op2_i;
            dest_q  <= bus.rd_addr_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (bus.flush_i) begin
            busy_q  <= 1'b0;
            state_q <= MD_IDLE;
          end else begin
            acc_q <= acc_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              rd_wen_q  <= 1'b1;
              rd_addr_q <= dest_q;
              rd_data_q <= (op_q == MD_OP_MUL) ? acc_d[DATA_W-1:0] : op1_d;
              state_q   <= MD_DONE;
            end
          end
        end
        MD_DONE: begin
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign bus.hold_o    = ((state_q == MD_IDLE) && bus.start_i && !bus.flush_i) ||
                         (state_q == MD_CALC);
  assign bus.busy_o    = busy_q;
  assign bus.rd_wen_o  = rd_wen_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_data_o = rd_data_q;

endmodule
